// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM states,
// exception vector offsets and the codebase-wide reset/zero constants.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN,
        WAIT_IF
    } ctrlState_e;

    localparam logic [31:0] EXC_OFFSET_GENERAL = 32'h0000_0180;
    localparam logic [31:0] EXC_OFFSET_REFILL  = 32'h0000_0000;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // ERET returns to EPC; everything else vectors off EBASE (wrapping add)
    function automatic logic [31:0] excTarget(
        input logic        isEret,
        input logic        tlbRefill,
        input logic [31:0] ebase,
        input logic [31:0] epc
    );
        if (isEret)
            excTarget = epc;
        else
            excTarget = ebase + (tlbRefill ? EXC_OFFSET_REFILL : EXC_OFFSET_GENERAL);
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: maps per-stage stall requests onto register
// enables, and turns MEM-stage exceptions/ERET into a one-cycle flush + redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        if_busy,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        except_valid,
    input  logic        except_is_eret,
    input  logic        except_tlb_refill,
    input  logic [31:0] cp0_ebase,
    input  logic [31:0] cp0_epc,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    ctrlState_e  r_state;
    ctrlState_e  w_nextState;
    logic [31:0] r_pendPc;
    logic [31:0] r_stallCycles;
    logic [31:0] r_flushCount;
    logic [31:0] w_target;
    logic [4:0]  w_en;
    logic        w_flush;
    logic [31:0] w_newPc;
    logic        w_latchPend;
    logic        w_accept;

    assign w_target = excTarget(except_is_eret, except_tlb_refill, cp0_ebase, cp0_epc);
    // A data-bus transaction in flight must finish before MEM can be squashed
    assign w_accept = except_valid && !stallreq_mem;

    // w_en bit order: {pc, if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        w_nextState = r_state;
        w_en        = 5'b11111;
        w_flush     = 1'b0;
        w_newPc     = ZeroWord;
        w_latchPend = 1'b0;
        if (rst != RstEnable) begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        if (if_busy) begin
                            w_en        = 5'b00000;
                            w_latchPend = 1'b1;
                            w_nextState = WAIT_IF;
                        end else begin
                            w_flush = 1'b1;
                            w_newPc = w_target;
                        end
                    end else if (stallreq_mem) begin
                        w_en = 5'b00001;
                    end else if (stallreq_ex) begin
                        w_en = 5'b00011;
                    end else if (stallreq_id) begin
                        w_en = 5'b00111;
                    end else if (stallreq_if) begin
                        w_en = 5'b01111;
                    end
                end
                WAIT_IF: begin
                    if (if_busy) begin
                        w_en = 5'b00000;
                    end else begin
                        w_flush     = 1'b1;
                        w_newPc     = r_pendPc;
                        w_nextState = RUN;
                    end
                end
                default: w_nextState = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state       <= RUN;
            r_pendPc      <= ZeroWord;
            r_stallCycles <= ZeroWord;
            r_flushCount  <= ZeroWord;
        end else begin
            r_state <= w_nextState;
            if (w_latchPend)
                r_pendPc <= w_target;
            if (!w_en[4])
                r_stallCycles <= r_stallCycles + 32'd1;
            if (w_flush)
                r_flushCount <= r_flushCount + 32'd1;
        end
    end

    assign en_pc        = w_en[4];
    assign en_if_id     = w_en[3];
    assign en_id_ex     = w_en[2];
    assign en_ex_mem    = w_en[1];
    assign en_mem_wb    = w_en[0];
    assign flush        = w_flush;
    assign new_pc       = w_newPc;
    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;

endmodule
